// File: rtl/mux_capture_reg.sv
// NCH-channel select/capture register with manual and auto-scan modes.
// Optional sel_err counter output enabled by defining MUX_CAPTURE_ERRCNT_EN.
module mux_capture_reg #(
  parameter int WIDTH    = 2,
  parameter int NCH      = 3,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] idata,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 le,
  input  logic                 mode,
  output logic [WIDTH-1:0]     y,
  output logic [SEL_W-1:0]     ch,
  output logic                 upd,
  output logic                 sel_err
`ifdef MUX_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             upd_q, upd_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] sel_data, scan_data;
  logic             sel_ok;

  // Explicit compare loops keep out-of-range selects from indexing past idata.
  always_comb begin
    sel_data  = '0;
    scan_data = '0;
    sel_ok    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel) == k) begin
        sel_data = idata[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
      if (int'(idx_q) == k) scan_data = idata[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_d       = y_q;
    ch_d      = ch_q;
    upd_d     = 1'b0;
    sel_err_d = 1'b0;
    idx_d     = idx_q;
    div_d     = div_q;
    mode_d    = mode;
    if (mode != mode_q) begin
      idx_d = '0;
      div_d = '0;
    end else if (!mode) begin
      if (le) begin
        if (sel_ok) begin
          y_d   = sel_data;
          ch_d  = sel;
          upd_d = 1'b1;
        end else begin
          sel_err_d = 1'b1;
        end
      end
    end else if (le) begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        y_d   = scan_data;
        ch_d  = idx_q;
        upd_d = 1'b1;
        div_d = '0;
        idx_d = (idx_q == SEL_W'(NCH - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      ch_q      <= '0;
      upd_q     <= 1'b0;
      sel_err_q <= 1'b0;
      idx_q     <= '0;
      div_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      y_q       <= y_d;
      ch_q      <= ch_d;
      upd_q     <= upd_d;
      sel_err_q <= sel_err_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
    end
  end

  assign y       = y_q;
  assign ch      = ch_q;
  assign upd     = upd_q;
  assign sel_err = sel_err_q;

`ifdef MUX_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturates rather than wrapping so a long error burst stays visible.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sel_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
